// File: rtl/mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_if
//   Signal bundle around the main-memory controller: the icache and dcache
//   request/response channels and the single main-memory port.
//
//   Modports
//     slave  : controller view. Takes requests, returns responses and drives
//              the main-memory strobes/address/write data.
//     master : environment view (caches plus memory array).
//
//   Signals
//     ic_req_valid/type/block_addr, ic_req_ready      icache request handshake
//     ic_resp_valid/block_data                        icache one-cycle response
//     dc_req_valid/type/block_addr/block_data, ready  dcache request handshake
//     dc_resp_valid/block_data                        dcache one-cycle response
//     mem_rd_en/wr_en/addr/wdata                      main-memory command
//     mem_rdata                                       main-memory read data,
//                                                     valid one cycle after
//                                                     mem_rd_en
// ---------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int unsigned BLOCK_DATA_WIDTH = 64,
  parameter int unsigned BLOCK_ADDR_WIDTH = 29
);

  // icache channel
  logic                        ic_req_valid;
  logic                        ic_req_type;
  logic [BLOCK_ADDR_WIDTH-1:0] ic_req_block_addr;
  logic                        ic_req_ready;
  logic                        ic_resp_valid;
  logic [BLOCK_DATA_WIDTH-1:0] ic_resp_block_data;

  // dcache channel
  logic                        dc_req_valid;
  logic                        dc_req_type;
  logic [BLOCK_ADDR_WIDTH-1:0] dc_req_block_addr;
  logic [BLOCK_DATA_WIDTH-1:0] dc_req_block_data;
  logic                        dc_req_ready;
  logic                        dc_resp_valid;
  logic [BLOCK_DATA_WIDTH-1:0] dc_resp_block_data;

  // main-memory port
  logic                        mem_rd_en;
  logic                        mem_wr_en;
  logic [BLOCK_ADDR_WIDTH-1:0] mem_addr;
  logic [BLOCK_DATA_WIDTH-1:0] mem_wdata;
  logic [BLOCK_DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ic_req_valid,
    input  ic_req_type,
    input  ic_req_block_addr,
    output ic_req_ready,
    output ic_resp_valid,
    output ic_resp_block_data,
    input  dc_req_valid,
    input  dc_req_type,
    input  dc_req_block_addr,
    input  dc_req_block_data,
    output dc_req_ready,
    output dc_resp_valid,
    output dc_resp_block_data,
    output mem_rd_en,
    output mem_wr_en,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ic_req_valid,
    output ic_req_type,
    output ic_req_block_addr,
    input  ic_req_ready,
    input  ic_resp_valid,
    input  ic_resp_block_data,
    output dc_req_valid,
    output dc_req_type,
    output dc_req_block_addr,
    output dc_req_block_data,
    input  dc_req_ready,
    input  dc_resp_valid,
    input  dc_resp_block_data,
    input  mem_rd_en,
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//   Single-ported main-memory controller sitting below the icache and the
//   dcache. Accepts block-granular READ/WRITE requests, arbitrates with
//   icache priority, and runs one transaction at a time against a
//   synchronous-read memory array. Every accepted request receives exactly
//   one single-cycle response MEM_LATENCY cycles after acceptance.
//
//   Parameters
//     BLOCK_DATA_WIDTH  bits per cache block
//     BLOCK_ADDR_WIDTH  block address width
//     MEM_LATENCY       accept-to-response distance in cycles (2..15)
//
//   Ports
//     clk   clock
//     rst   synchronous reset, active-high
//     bus   mem_ctrl_if.slave: both cache channels and the memory port
//
//   Timeline of one transaction (cycle 0 = accepting cycle):
//     0               valid & ready, request latched, counter = MEM_LATENCY-1
//     1..MEM_LATENCY-1  BUSY, counter counts down
//     MEM_LATENCY-1   counter == 1: exactly one memory strobe
//     MEM_LATENCY     RESP: one response pulse to the latched requester
//     MEM_LATENCY+1   IDLE, ready again
// ---------------------------------------------------------------------------
module mem_ctrl #(
  parameter int unsigned BLOCK_DATA_WIDTH = 64,
  parameter int unsigned BLOCK_ADDR_WIDTH = 29,
  parameter int unsigned MEM_LATENCY      = 4
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Counter is wide enough for the largest legal latency (15).
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      state_nx_s;
  logic [3:0]                  cnt_r;
  logic [3:0]                  cnt_nx_s;

  // Latched transaction: requester (1 = dcache), type, address, write data.
  logic                        req_dc_r;
  logic                        req_wr_r;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_r;
  logic [BLOCK_DATA_WIDTH-1:0] data_r;

  logic                        ic_rdy_s;
  logic                        dc_rdy_s;
  logic                        ic_acc_s;
  logic                        dc_acc_s;

  logic                        mem_rd_en_s;
  logic                        mem_wr_en_s;
  logic [BLOCK_ADDR_WIDTH-1:0] mem_addr_s;
  logic [BLOCK_DATA_WIDTH-1:0] mem_wdata_s;
  logic                        ic_resp_valid_s;
  logic [BLOCK_DATA_WIDTH-1:0] ic_resp_data_s;
  logic                        dc_resp_valid_s;
  logic [BLOCK_DATA_WIDTH-1:0] dc_resp_data_s;

  // Ready/arbitration: icache wins whenever it is valid in IDLE.
  // Both readies are held low while rst is asserted so nothing is accepted
  // in a reset cycle.
  always_comb begin
    ic_rdy_s = 1'b0;
    dc_rdy_s = 1'b0;
    if ((state_r == ST_IDLE) && !rst) begin
      ic_rdy_s = 1'b1;
      dc_rdy_s = !bus.ic_req_valid;
    end else begin
      ic_rdy_s = 1'b0;
      dc_rdy_s = 1'b0;
    end
    ic_acc_s = bus.ic_req_valid & ic_rdy_s;
    dc_acc_s = bus.dc_req_valid & dc_rdy_s;
  end

  // State register, countdown and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      req_dc_r <= 1'b0;
      req_wr_r <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (ic_acc_s) begin
        req_dc_r <= 1'b0;
        req_wr_r <= bus.ic_req_type;
        addr_r   <= bus.ic_req_block_addr;
        data_r   <= '0;
      end else if (dc_acc_s) begin
        req_dc_r <= 1'b1;
        req_wr_r <= bus.dc_req_type;
        addr_r   <= bus.dc_req_block_addr;
        data_r   <= bus.dc_req_block_data;
      end else begin
        req_dc_r <= req_dc_r;
        req_wr_r <= req_wr_r;
        addr_r   <= addr_r;
        data_r   <= data_r;
      end
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (ic_acc_s || dc_acc_s) begin
          state_nx_s = ST_BUSY;
          cnt_nx_s   = CNT_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 4'd0;
        end
      end
      ST_BUSY: begin
        // The strobe cycle (counter == 1) is the last BUSY cycle.
        cnt_nx_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Memory command and response decode from the current state.
  // Every output is forced low while rst is high.
  always_comb begin
    mem_rd_en_s     = 1'b0;
    mem_wr_en_s     = 1'b0;
    mem_addr_s      = '0;
    mem_wdata_s     = '0;
    ic_resp_valid_s = 1'b0;
    ic_resp_data_s  = '0;
    dc_resp_valid_s = 1'b0;
    dc_resp_data_s  = '0;
    if (rst) begin
      mem_rd_en_s = 1'b0;
      mem_wr_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_BUSY: begin
          if (cnt_r == 4'd1) begin
            mem_rd_en_s = (req_wr_r == REQ_READ);
            mem_wr_en_s = (req_wr_r == REQ_WRITE);
            mem_addr_s  = addr_r;
            mem_wdata_s = data_r;
          end else begin
            mem_rd_en_s = 1'b0;
            mem_wr_en_s = 1'b0;
          end
        end
        ST_RESP: begin
          // A write response echoes the latched data so the cache can
          // release its pending write.
          if (req_dc_r) begin
            dc_resp_valid_s = 1'b1;
            dc_resp_data_s  = req_wr_r ? data_r : bus.mem_rdata;
          end else begin
            ic_resp_valid_s = 1'b1;
            ic_resp_data_s  = req_wr_r ? data_r : bus.mem_rdata;
          end
        end
        default: begin
          mem_rd_en_s = 1'b0;
          mem_wr_en_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.ic_req_ready       = ic_rdy_s;
  assign bus.dc_req_ready       = dc_rdy_s;
  assign bus.ic_resp_valid      = ic_resp_valid_s;
  assign bus.ic_resp_block_data = ic_resp_data_s;
  assign bus.dc_resp_valid      = dc_resp_valid_s;
  assign bus.dc_resp_block_data = dc_resp_data_s;
  assign bus.mem_rd_en          = mem_rd_en_s;
  assign bus.mem_wr_en          = mem_wr_en_s;
  assign bus.mem_addr           = mem_addr_s;
  assign bus.mem_wdata          = mem_wdata_s;

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//   Two controllers: dut4 (MEM_LATENCY=4) for directed and random traffic,
//   dut2 (MEM_LATENCY=2) for back-to-back timing. Each has a behavioural
//   synchronous-read memory. A scoreboard on dut4 pushes each accepted
//   request and pops it at the response, computing the expected data from a
//   reference memory that is only updated when a write response appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int DW = 64;
  localparam int AW = 29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst2;

  mem_ctrl_if #(.BLOCK_DATA_WIDTH(DW), .BLOCK_ADDR_WIDTH(AW)) bus4 ();
  mem_ctrl_if #(.BLOCK_DATA_WIDTH(DW), .BLOCK_ADDR_WIDTH(AW)) bus2 ();

  mem_ctrl #(.BLOCK_DATA_WIDTH(DW), .BLOCK_ADDR_WIDTH(AW), .MEM_LATENCY(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  mem_ctrl #(.BLOCK_DATA_WIDTH(DW), .BLOCK_ADDR_WIDTH(AW), .MEM_LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // Memory arrays (only the low 8 address bits are used by the bench).
  logic [DW-1:0] mem4 [256];
  logic [DW-1:0] mem2 [256];
  logic          mem_clr;
  logic          pre4_we;
  logic          pre2_we;
  logic [7:0]    pre_addr;
  logic [DW-1:0] pre_data;

  // Behavioural main memories with a preload port.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem4[i] <= '0;
        mem2[i] <= '0;
      end
    end else begin
      if (pre4_we) mem4[pre_addr] <= pre_data;
      if (pre2_we) mem2[pre_addr] <= pre_data;
      if (bus4.mem_wr_en) mem4[bus4.mem_addr[7:0]] <= bus4.mem_wdata;
      if (bus4.mem_rd_en) bus4.mem_rdata <= mem4[bus4.mem_addr[7:0]];
      if (bus2.mem_wr_en) mem2[bus2.mem_addr[7:0]] <= bus2.mem_wdata;
      if (bus2.mem_rd_en) bus2.mem_rdata <= mem2[bus2.mem_addr[7:0]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference memory and scoreboard for dut4.
  logic [DW-1:0] ref4 [256];

  typedef struct packed {
    logic          dc;
    logic          wr;
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t sb_q[$];
  int   acc_cnt   = 0;
  int   resp_cnt  = 0;
  int   abort_cnt = 0;

  initial begin
    txn_t          t;
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      if (rst4) begin
        abort_cnt += sb_q.size();
        sb_q.delete();
      end else begin
        if (bus4.ic_req_valid && bus4.ic_req_ready) begin
          t.dc = 1'b0; t.wr = bus4.ic_req_type;
          t.addr = bus4.ic_req_block_addr[7:0]; t.data = '0;
          sb_q.push_back(t);
          acc_cnt++;
        end
        if (bus4.dc_req_valid && bus4.dc_req_ready) begin
          t.dc = 1'b1; t.wr = bus4.dc_req_type;
          t.addr = bus4.dc_req_block_addr[7:0]; t.data = bus4.dc_req_block_data;
          sb_q.push_back(t);
          acc_cnt++;
        end
        check_eq("rd_wr_excl", 64'(bus4.mem_rd_en & bus4.mem_wr_en), 64'd0);
        check_eq("resp_excl", 64'(bus4.ic_resp_valid & bus4.dc_resp_valid), 64'd0);
        if (bus4.ic_resp_valid || bus4.dc_resp_valid) begin
          resp_cnt++;
          check_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            t = sb_q.pop_front();
            exp_d = t.wr ? t.data : ref4[t.addr];
            check_eq("sb_port", 64'(bus4.dc_resp_valid), 64'(t.dc));
            if (t.dc) begin
              check_eq("sb_dc_data", bus4.dc_resp_block_data, exp_d);
              check_eq("sb_ic_idle_data", bus4.ic_resp_block_data, 64'd0);
            end else begin
              check_eq("sb_ic_data", bus4.ic_resp_block_data, exp_d);
              check_eq("sb_dc_idle_data", bus4.dc_resp_block_data, 64'd0);
            end
            if (t.wr) ref4[t.addr] = t.data;
          end
        end
      end
    end
  end

  task automatic preload4(input logic [7:0] a, input logic [63:0] d);
    pre_addr = a; pre_data = d; pre4_we = 1'b1;
    tick();
    pre4_we = 1'b0;
    ref4[a] = d;
  endtask

  task automatic preload2(input logic [7:0] a, input logic [63:0] d);
    pre_addr = a; pre_data = d; pre2_we = 1'b1;
    tick();
    pre2_we = 1'b0;
  endtask

  // dcache READ on dut4, expecting data d in cycle 4.
  task automatic dc_read4(input string tag, input logic [28:0] a, input logic [63:0] d);
    bus4.dc_req_valid = 1'b1; bus4.dc_req_type = 1'b0; bus4.dc_req_block_addr = a;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus4.dc_req_valid = 1'b0;
      @(negedge clk);
      check_eq({tag, "_rd_en"}, 64'(bus4.mem_rd_en), 64'(k == 3));
      check_eq({tag, "_resp"}, 64'(bus4.dc_resp_valid), 64'(k == 4));
      if (k == 4) check_eq({tag, "_data"}, bus4.dc_resp_block_data, d);
      tick();
    end
  endtask

  // Random mixed traffic on dut4; requests are held until accepted.
  task automatic run_random(input int n);
    int   issued = 0;
    int   stall  = 0;
    logic icp    = 1'b0;
    logic dcp    = 1'b0;
    logic ia;
    logic da;
    while ((issued < n || icp || dcp) && stall <= 200) begin
      if (!icp && issued < n && $urandom_range(0, 7) == 0) begin
        icp = 1'b1; issued++;
        bus4.ic_req_valid = 1'b1; bus4.ic_req_type = 1'b0;
        bus4.ic_req_block_addr = 29'($urandom_range(0, 63));
      end
      if (!dcp && issued < n && $urandom_range(0, 2) == 0) begin
        dcp = 1'b1; issued++;
        bus4.dc_req_valid = 1'b1;
        bus4.dc_req_type = 1'($urandom_range(0, 1));
        bus4.dc_req_block_addr = 29'($urandom_range(0, 63));
        bus4.dc_req_block_data = {$urandom, $urandom};
      end
      @(negedge clk);
      ia = bus4.ic_req_valid & bus4.ic_req_ready;
      da = bus4.dc_req_valid & bus4.dc_req_ready;
      tick();
      if (ia) begin icp = 1'b0; bus4.ic_req_valid = 1'b0; end
      if (da) begin dcp = 1'b0; bus4.dc_req_valid = 1'b0; end
      if ((icp || dcp) && !ia && !da) stall++;
      else stall = 0;
    end
    check_eq("rand_no_stall", 64'(stall > 200), 64'd0);
    check_eq("rand_issued", 64'(issued), 64'(n));
    bus4.ic_req_valid = 1'b0;
    bus4.dc_req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1; rst2 = 1'b1; mem_clr = 1'b1;
    pre4_we = 1'b0; pre2_we = 1'b0; pre_addr = 8'd0; pre_data = 64'd0;
    bus4.ic_req_valid = 1'b0; bus4.ic_req_type = 1'b0; bus4.ic_req_block_addr = 29'd0;
    bus4.dc_req_valid = 1'b0; bus4.dc_req_type = 1'b0; bus4.dc_req_block_addr = 29'd0;
    bus4.dc_req_block_data = 64'd0;
    bus2.ic_req_valid = 1'b0; bus2.ic_req_type = 1'b0; bus2.ic_req_block_addr = 29'd0;
    bus2.dc_req_valid = 1'b0; bus2.dc_req_type = 1'b0; bus2.dc_req_block_addr = 29'd0;
    bus2.dc_req_block_data = 64'd0;
    for (int i = 0; i < 256; i++) ref4[i] = 64'd0;
    repeat (3) tick();

    // Reset state: everything low while rst is high.
    @(negedge clk);
    check_eq("rst_ic_rdy", 64'(bus4.ic_req_ready), 64'd0);
    check_eq("rst_resp", 64'(bus4.ic_resp_valid | bus4.dc_resp_valid), 64'd0);
    check_eq("rst_strobe", 64'(bus4.mem_rd_en | bus4.mem_wr_en), 64'd0);
    tick();
    rst4 = 1'b0; rst2 = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ic_rdy4", 64'(bus4.ic_req_ready), 64'd1);
    check_eq("post_rst_dc_rdy4", 64'(bus4.dc_req_ready), 64'd1);
    check_eq("post_rst_ic_rdy2", 64'(bus2.ic_req_ready), 64'd1);
    check_eq("post_rst_addr", 64'(bus4.mem_addr), 64'd0);
    tick();

    // 1: icache READ of 0x10.
    preload4(8'h10, 64'hDEADBEEF_CAFEF00D);
    bus4.ic_req_valid = 1'b1; bus4.ic_req_type = 1'b0; bus4.ic_req_block_addr = 29'h10;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus4.ic_req_valid = 1'b0;
      @(negedge clk);
      check_eq("t1_ic_rdy", 64'(bus4.ic_req_ready), 64'(k == 0 || k == 5));
      check_eq("t1_rd_en", 64'(bus4.mem_rd_en), 64'(k == 3));
      check_eq("t1_ic_resp", 64'(bus4.ic_resp_valid), 64'(k == 4));
      if (k == 3) check_eq("t1_addr", 64'(bus4.mem_addr), 64'h10);
      if (k == 4) check_eq("t1_data", bus4.ic_resp_block_data, 64'hDEADBEEF_CAFEF00D);
      tick();
    end

    // 2: dcache WRITE of 0x20, then read it back.
    bus4.dc_req_valid = 1'b1; bus4.dc_req_type = 1'b1; bus4.dc_req_block_addr = 29'h20;
    bus4.dc_req_block_data = 64'h11223344_55667788;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus4.dc_req_valid = 1'b0;
      @(negedge clk);
      check_eq("t2_wr_en", 64'(bus4.mem_wr_en), 64'(k == 3));
      check_eq("t2_rd_en", 64'(bus4.mem_rd_en), 64'd0);
      check_eq("t2_dc_resp", 64'(bus4.dc_resp_valid), 64'(k == 4));
      if (k == 3) begin
        check_eq("t2_wdata", bus4.mem_wdata, 64'h11223344_55667788);
        check_eq("t2_addr", 64'(bus4.mem_addr), 64'h20);
      end else begin
        check_eq("t2_wdata_idle", bus4.mem_wdata, 64'd0);
      end
      if (k == 4) check_eq("t2_echo", bus4.dc_resp_block_data, 64'h11223344_55667788);
      tick();
    end
    dc_read4("t2_rb", 29'h20, 64'h11223344_55667788);

    // 3: simultaneous icache and dcache READs.
    preload4(8'h01, 64'h0101_0101_AAAA_0001);
    preload4(8'h02, 64'h0202_0202_BBBB_0002);
    bus4.ic_req_valid = 1'b1; bus4.ic_req_type = 1'b0; bus4.ic_req_block_addr = 29'h1;
    bus4.dc_req_valid = 1'b1; bus4.dc_req_type = 1'b0; bus4.dc_req_block_addr = 29'h2;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) bus4.ic_req_valid = 1'b0;
      if (k == 6) bus4.dc_req_valid = 1'b0;
      @(negedge clk);
      check_eq("t3_ic_rdy", 64'(bus4.ic_req_ready), 64'(k == 0 || k == 5));
      check_eq("t3_dc_rdy", 64'(bus4.dc_req_ready), 64'(k == 5));
      check_eq("t3_rd_en", 64'(bus4.mem_rd_en), 64'(k == 3 || k == 8));
      check_eq("t3_ic_resp", 64'(bus4.ic_resp_valid), 64'(k == 4));
      check_eq("t3_dc_resp", 64'(bus4.dc_resp_valid), 64'(k == 9));
      if (k == 4) check_eq("t3_ic_data", bus4.ic_resp_block_data, 64'h0101_0101_AAAA_0001);
      if (k == 9) check_eq("t3_dc_data", bus4.dc_resp_block_data, 64'h0202_0202_BBBB_0002);
      tick();
    end

    // 4: reset in cycle 2 of a dcache WRITE aborts it.
    preload4(8'h30, 64'h5A5A_0000_3030_A5A5);
    bus4.dc_req_valid = 1'b1; bus4.dc_req_type = 1'b1; bus4.dc_req_block_addr = 29'h30;
    bus4.dc_req_block_data = 64'hFFFF_EEEE_DDDD_CCCC;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) bus4.dc_req_valid = 1'b0;
      if (k == 2) rst4 = 1'b1;
      if (k == 3) rst4 = 1'b0;
      @(negedge clk);
      check_eq("t4_wr_en", 64'(bus4.mem_wr_en), 64'd0);
      check_eq("t4_dc_resp", 64'(bus4.dc_resp_valid), 64'd0);
      check_eq("t4_ic_rdy", 64'(bus4.ic_req_ready), 64'(k == 0 || k >= 3));
      tick();
    end
    dc_read4("t4_rb", 29'h30, 64'h5A5A_0000_3030_A5A5);

    // 5: MEM_LATENCY=2 back-to-back dcache READs with valid held.
    preload2(8'h05, 64'h0505_0505_0505_0505);
    preload2(8'h06, 64'h6060_6060_6060_6060);
    bus2.dc_req_valid = 1'b1; bus2.dc_req_type = 1'b0; bus2.dc_req_block_addr = 29'h5;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) bus2.dc_req_block_addr = 29'h6;
      if (k == 4) bus2.dc_req_valid = 1'b0;
      @(negedge clk);
      check_eq("t5_dc_rdy", 64'(bus2.dc_req_ready), 64'(k == 0 || k == 3));
      check_eq("t5_rd_en", 64'(bus2.mem_rd_en), 64'(k == 1 || k == 4));
      check_eq("t5_dc_resp", 64'(bus2.dc_resp_valid), 64'(k == 2 || k == 5));
      if (k == 1) check_eq("t5_addr0", 64'(bus2.mem_addr), 64'h5);
      if (k == 4) check_eq("t5_addr1", 64'(bus2.mem_addr), 64'h6);
      if (k == 2) check_eq("t5_data0", bus2.dc_resp_block_data, 64'h0505_0505_0505_0505);
      if (k == 5) check_eq("t5_data1", bus2.dc_resp_block_data, 64'h6060_6060_6060_6060);
      tick();
    end

    // 6: random mixed traffic.
    run_random(1000);
    repeat (10) tick();
    check_eq("resp_eq_acc", 64'(resp_cnt), 64'(acc_cnt - abort_cnt));
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
